// File: rtl/scr_loader.sv
// Screen-image loader: maps an incoming byte stream onto VRAM / ULA+ palette /
// Timex mode writes, buffering through a small FIFO so VRAM writes use free slots only.
module scr_loader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  fmt,
    input  logic        page,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        vram_slot,
    output logic        vram_we,
    output logic [14:0] vram_waddr,
    output logic [7:0]  vram_wdata,
    output logic        pal_we,
    output logic [5:0]  pal_addr,
    output logic [7:0]  pal_data,
    output logic        tmx_we,
    output logic [7:0]  tmx_data,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0] T_VRAM = 2'd0;
    localparam logic [1:0] T_PAL  = 2'd1;
    localparam logic [1:0] T_TMX  = 2'd2;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ERR} state_t;
    state_t state, state_nx;

    logic [1:0]    fmt_q;
    logic          page_q;
    logic [13:0]   byte_cnt;
    logic [13:0]   last_idx;
    logic [12:0]   hi_off;
    logic [1:0]    push_type;
    logic [14:0]   push_addr;
    logic [24:0]   mem [FIFO_DEPTH];
    logic [24:0]   head;
    logic [1:0]    head_type;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, pop, push, start_go, done_nx;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign head_type = head[24:23];
    assign pop       = !empty && !abort && (head_type != T_VRAM || vram_slot);
    // A certain pop this cycle frees a slot, so a full FIFO can still accept.
    assign s_ready   = (state == LOAD) && (!full || pop);
    assign push      = s_valid && s_ready;
    assign busy      = (state == LOAD) || (state == DRAIN);
    assign start_go  = (state == IDLE) && start && !abort;
    assign hi_off    = byte_cnt[12:0] - 13'd6144;

    always_comb begin
        last_idx = 14'd6911;
        case (fmt_q)
            2'd0: last_idx = 14'd6911;
            2'd1: last_idx = 14'd6975;
            2'd2: last_idx = 14'd12287;
            2'd3: last_idx = 14'd12288;
            default: last_idx = 14'd6911;
        endcase
    end

    // 6912 is a multiple of 64, so the palette index is simply the low 6 count bits.
    always_comb begin
        push_type = T_VRAM;
        push_addr = {page_q, 1'b0, byte_cnt[12:0]};
        if (!fmt_q[1]) begin
            if (byte_cnt >= 14'd6912) begin
                push_type = T_PAL;
                push_addr = {9'd0, byte_cnt[5:0]};
            end
        end else if (byte_cnt >= 14'd12288) begin
            push_type = T_TMX;
            push_addr = '0;
        end else if (byte_cnt >= 14'd6144) begin
            push_addr = {page_q, 1'b1, hi_off};
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = LOAD;
            LOAD:  if (push && (s_last || byte_cnt == last_idx))
                       state_nx = (s_last && byte_cnt == last_idx) ? DRAIN : ERR;
            DRAIN: if (empty) begin
                       state_nx = IDLE;
                       done_nx  = 1'b1;
                   end
            ERR:   if (empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= {push_type, push_addr, s_data};
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            fmt_q      <= '0;
            page_q     <= 1'b0;
            byte_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
            pal_we     <= 1'b0;
            pal_addr   <= '0;
            pal_data   <= '0;
            tmx_we     <= 1'b0;
            tmx_data   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state   <= state_nx;
            done    <= done_nx;
            vram_we <= pop && (head_type == T_VRAM);
            pal_we  <= pop && (head_type == T_PAL);
            tmx_we  <= pop && (head_type == T_TMX);
            if (pop && head_type == T_VRAM) begin
                vram_waddr <= head[22:8];
                vram_wdata <= head[7:0];
            end
            if (pop && head_type == T_PAL) begin
                pal_addr <= head[13:8];
                pal_data <= head[7:0];
            end
            if (pop && head_type == T_TMX) tmx_data <= head[7:0];
            if (start_go) begin
                fmt_q    <= fmt;
                page_q   <= page;
                byte_cnt <= '0;
            end else if (push) begin
                byte_cnt <= byte_cnt + 14'd1;
            end
            if (state_nx == ERR)  err <= 1'b1;
            else if (start_go)    err <= 1'b0;
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end
endmodule

// File: tb/tb_scr_loader.sv
// Bench for scr_loader: drives byte streams, predicts every write strobe into a
// scoreboard queue and matches strobes in order as they appear.
module tb_scr_loader;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [1:0]  fmt = 2'd0;
    logic        page = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0, s_last = 1'b0;
    logic        s_ready;
    logic        vram_slot = 1'b1;
    logic        vram_we, pal_we, tmx_we, busy, done, err;
    logic [14:0] vram_waddr;
    logic [7:0]  vram_wdata, pal_data, tmx_data;
    logic [5:0]  pal_addr;

    int checks = 0, failures = 0;
    int cyc = 0, last_strobe_cyc = 0;
    int slot_mode = 0;
    int nvram, npal, ntmx, ndone, stalls;
    logic [31:0] first_vram, last_vram, last_pal;
    logic [7:0]  tmx_val, last_data;
    logic [31:0] exp_q[$];

    scr_loader #(.FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort),
        .fmt(fmt), .page(page), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .vram_slot(vram_slot),
        .vram_we(vram_we), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .tmx_we(tmx_we), .tmx_data(tmx_data), .busy(busy), .done(done), .err(err)
    );

    // clock and slot pattern
    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc++;
    always @(posedge clk_sys) begin
        #1;
        case (slot_mode)
            0: vram_slot = 1'b1;
            1: vram_slot = (cyc % 4 == 0);
            2: vram_slot = 1'b0;
            default: vram_slot = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // reference mapping: {type, addr, data}; type 0 VRAM, 1 palette, 2 Timex
    function automatic logic [31:0] model(input int f, input bit pg, input int n, input logic [7:0] d);
        int base, a;
        base = pg ? 16384 : 0;
        if (f < 2) begin
            if (n < 6912) return {9'd0, 15'(base + n), d};
            return {7'd0, 2'd1, 9'd0, 6'(n - 6912), d};
        end
        if (n >= 12288) return {7'd0, 2'd2, 15'd0, d};
        a = (n < 6144) ? n : 8192 + (n - 6144);
        return {9'd0, 15'(base + a), d};
    endfunction

    // scoreboard monitor
    always @(negedge clk_sys) begin
        logic [31:0] got;
        if (vram_we || pal_we || tmx_we) begin
            check("one_strobe", 32'(int'(vram_we) + int'(pal_we) + int'(tmx_we)), 32'd1);
            got = 32'd0;
            if (vram_we) begin
                got = {9'd0, vram_waddr, vram_wdata};
                if (nvram == 0) first_vram = got;
                last_vram = got;
                nvram++;
            end else if (pal_we) begin
                got = {7'd0, 2'd1, 9'd0, pal_addr, pal_data};
                last_pal = got;
                npal++;
            end else begin
                got = {7'd0, 2'd2, 15'd0, tmx_data};
                tmx_val = tmx_data;
                ntmx++;
            end
            if (exp_q.size() == 0) check("unexpected_write", got, 32'hFFFF_FFFF);
            else check("write", got, exp_q.pop_front());
            last_strobe_cyc = cyc;
        end
        if (done) begin
            ndone++;
            check("done_after_strobe", 32'(cyc - last_strobe_cyc), 32'd1);
            check("busy_with_done", 32'(busy), 32'd0);
        end
    end

    task automatic clear_stats();
        nvram = 0; npal = 0; ntmx = 0; ndone = 0; stalls = 0;
        first_vram = '0; last_vram = '0; last_pal = '0; tmx_val = '0;
    endtask

    task automatic do_start(input logic [1:0] f, input bit pg);
        fmt = f; page = pg; start = 1'b1;
        @(posedge clk_sys); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input int f, input bit pg, input int n, input logic [7:0] d,
                             input bit last, output bit ok);
        ok = 1'b0;
        s_data = d; s_valid = 1'b1; s_last = last;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk_sys);
            if (s_ready) begin
                exp_q.push_back(model(f, pg, n, d));
                ok = 1'b1;
            end else if (busy) begin
                stalls++;
            end
            @(posedge clk_sys); #1;
            if (ok) break;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_stream(input int f, input bit pg, input int nbytes, input int last_at, input bit rnd);
        logic [7:0] d;
        bit ok;
        for (int n = 0; n < nbytes; n++) begin
            d = rnd ? 8'($urandom_range(0, 255)) : 8'(n);
            if (f == 1 && n >= 6912) d = 8'(8'hC0 + (n - 6912));
            last_data = d;
            send_byte(f, pg, n, d, n == last_at, ok);
            if (!ok) break;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int w = 0; w < 400; w++) begin
            @(negedge clk_sys);
            if (!busy) begin idle = 1'b1; break; end
        end
        if (!idle) check("idle_timeout", 32'd0, 32'd1);
        repeat (10) @(negedge clk_sys);
        @(posedge clk_sys); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_strobes"}, 32'({vram_we, pal_we, tmx_we}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_vram_bus"}, {9'd0, vram_waddr, vram_wdata}, 32'd0);
        check({tag, "_pal_bus"}, 32'({pal_addr, pal_data}), 32'd0);
        check({tag, "_tmx_data"}, 32'(tmx_data), 32'd0);
    endtask

    initial begin
        int n;
        logic seen_ready;
        clear_stats();
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_reset_outputs("reset");
        @(posedge clk_sys); #1;
        reset_n = 1'b1;

        // full SCR, page 1
        clear_stats();
        slot_mode = 0;
        do_start(2'd0, 1'b1);
        check("fmt0_busy", 32'(busy), 32'd1);
        run_stream(0, 1'b1, 6912, 6911, 1'b0);
        wait_idle();
        check("fmt0_nvram", 32'(nvram), 32'd6912);
        check("fmt0_first", first_vram, {9'd0, 15'h4000, 8'h00});
        check("fmt0_last", last_vram, {9'd0, 15'h5AFF, 8'hFF});
        check("fmt0_done", 32'(ndone), 32'd1);
        check("fmt0_err", 32'(err), 32'd0);
        check("fmt0_queue", 32'(exp_q.size()), 32'd0);

        // short stream: s_last on byte 100
        clear_stats();
        do_start(2'd0, 1'b0);
        run_stream(0, 1'b0, 101, 100, 1'b1);
        wait_idle();
        check("short_nvram", 32'(nvram), 32'd101);
        check("short_err", 32'(err), 32'd1);
        check("short_done", 32'(ndone), 32'd0);
        s_valid = 1'b1; seen_ready = 1'b0;
        repeat (5) begin
            @(negedge clk_sys);
            seen_ready = seen_ready | s_ready;
        end
        @(posedge clk_sys); #1;
        s_valid = 1'b0;
        check("short_ready_low", 32'(seen_ready), 32'd0);
        check("short_err_sticky", 32'(err), 32'd1);

        // simultaneous start and abort in IDLE
        start = 1'b1; abort = 1'b1;
        @(posedge clk_sys); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk_sys);
        check("startabort_busy", 32'(busy), 32'd0);
        check("startabort_err", 32'(err), 32'd1);
        @(posedge clk_sys); #1;

        // abort mid-load with the FIFO stuck full
        clear_stats();
        do_start(2'd0, 1'b0);
        @(negedge clk_sys);
        check("abort_err_cleared", 32'(err), 32'd0);
        @(posedge clk_sys); #1;
        run_stream(0, 1'b0, 500, -1, 1'b0);
        slot_mode = 2;
        n = 500;
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 8'(n);
            @(negedge clk_sys);
            if (s_ready) begin
                exp_q.push_back(model(0, 1'b0, n, s_data));
                n++;
            end
            @(posedge clk_sys); #1;
        end
        @(negedge clk_sys);
        check("abort_full_stall", 32'(s_ready), 32'd0);
        @(posedge clk_sys); #1;
        s_valid = 1'b0;
        abort = 1'b1;
        @(posedge clk_sys); #1;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk_sys);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_ready", 32'(s_ready), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        n = nvram;
        slot_mode = 0;
        repeat (20) @(negedge clk_sys);
        check("abort_no_writes", 32'(nvram - n), 32'd0);
        check("abort_no_done", 32'(ndone), 32'd0);
        @(posedge clk_sys); #1;

        // SCR plus palette, random slots
        clear_stats();
        slot_mode = 3;
        do_start(2'd1, 1'b0);
        run_stream(1, 1'b0, 6976, 6975, 1'b0);
        wait_idle();
        check("fmt1_nvram", 32'(nvram), 32'd6912);
        check("fmt1_npal", 32'(npal), 32'd64);
        check("fmt1_last_pal", last_pal, {7'd0, 2'd1, 9'd0, 6'd63, 8'hFF});
        check("fmt1_done", 32'(ndone), 32'd1);
        check("fmt1_err", 32'(err), 32'd0);

        // reset in the middle of a Timex load
        clear_stats();
        do_start(2'd2, 1'b1);
        run_stream(2, 1'b1, 50, -1, 1'b1);
        reset_n = 1'b0;
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk_sys);
        check_reset_outputs("midreset");
        @(posedge clk_sys); #1;

        // Timex with mode byte, 1-in-4 slots
        clear_stats();
        slot_mode = 1;
        do_start(2'd3, 1'b0);
        check("fmt3_started", 32'(busy), 32'd1);
        run_stream(3, 1'b0, 12289, 12288, 1'b1);
        wait_idle();
        check("fmt3_nvram", 32'(nvram), 32'd12288);
        check("fmt3_last", last_vram[31:8], {9'd0, 15'h37FF});
        check("fmt3_ntmx", 32'(ntmx), 32'd1);
        check("fmt3_tmx_val", 32'(tmx_val), 32'(last_data));
        check("fmt3_stall_seen", 32'(stalls > 0), 32'd1);
        check("fmt3_done", 32'(ndone), 32'd1);
        check("fmt3_err", 32'(err), 32'd0);
        check("fmt3_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scr_loader.md
# scr_loader

Streams a screen image into video RAM: the write-side counterpart of the video controller's VRAM fetch path. It accepts a byte stream from the OSD/SPI file loader, maps each byte to a screen address (bitmap, attributes, Timex second screen), and issues VRAM writes only in slots the video fetcher leaves free. Optional trailing data programs the ULA+ palette or the Timex mode register through dedicated write strobes.

## Interface
Parameters:
- FIFO_DEPTH, 4: entries in the accept-to-write buffer; power of two, at least 2.

Ports:
- clk_sys  in  1  master clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE.
- abort  in  1  one-cycle pulse; cancels a load from any state.
- fmt  in  2  image format, latched at start:
  - 0: SCR, 6912 bytes.
  - 1: SCR + ULA+ palette, 6976 bytes.
  - 2: Timex, 12288 bytes.
  - 3: Timex + mode byte, 12289 bytes.
- page  in  1  target screen page, latched at start; becomes vram_waddr[14].
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_last  in  1  qualifies s_data as the final byte.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- vram_slot  in  1  VRAM write permitted this cycle; the video fetcher is idle.
- vram_we  out  1  VRAM write strobe.
- vram_waddr  out  15  VRAM write address.
- vram_wdata  out  8  VRAM write data.
- pal_we  out  1  ULA+ palette write strobe.
- pal_addr  out  6  palette index.
- pal_data  out  8  palette entry, GGGRRRBB.
- tmx_we  out  1  Timex mode register write strobe.
- tmx_data  out  8  Timex mode byte.
- busy  out  1  high in LOAD and DRAIN.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky length error; cleared by the next start.

## Operation
States are IDLE, LOAD, DRAIN and ERR.

- **IDLE**
  - On start: latch fmt and page, clear byte_cnt (14 bits), clear err, then go to LOAD.
- **LOAD**
  - s_ready = ~fifo_full.
  - Each accepted byte pushes {type, addr, data}, then byte_cnt increments.
  - Mapping, by byte index n:
    - fmt 0/1, n < 6912: VRAM, addr = {page, 1'b0, n[12:0]}.
    - fmt 1, 6912 ≤ n < 6976: palette, index = n - 6912.
    - fmt 2/3, n < 6144: VRAM, addr = {page, 1'b0, n[12:0]}.
    - fmt 2/3, 6144 ≤ n < 12288: VRAM, addr = {page, 1'b1, (n - 6144)[12:0]}.
    - fmt 3, n = 12288: Timex mode byte.
  - Expected length N comes from fmt.
  - Accepted byte with s_last and n = N-1: go to DRAIN.
  - Accepted byte with s_last and n < N-1: go to ERR.
  - Accepted byte with n = N-1 and no s_last: go to ERR.
- **DRAIN**
  - s_ready = 0.
  - When the FIFO is empty: pulse done, go to IDLE.
- **ERR**
  - s_ready = 0, err = 1.
  - The FIFO drains normally; bytes already accepted are still written.
  - When the FIFO is empty: go to IDLE, keeping err = 1.
- **FIFO pop rules**
  - Head of type VRAM: pops only in a cycle with vram_slot = 1, asserting vram_we for that cycle.
  - Head of type palette or Timex: pops unconditionally, asserting pal_we or tmx_we.
  - At most one pop per cycle.
- **abort**: next state IDLE, FIFO flushed, err unchanged, no done pulse. Pending writes are discarded; a write strobe in the abort cycle itself still completes.
- **start** outside IDLE is ignored.
- **Simultaneous start and abort** in IDLE: abort wins, state stays IDLE.

## Timing
- Reset values (reset_n = 0 at a clock edge):
  - state = IDLE, FIFO empty.
  - s_ready, vram_we, pal_we, tmx_we, busy, done, err = 0.
  - vram_waddr, vram_wdata, pal_addr, pal_data, tmx_data = 0.
- Reset has priority over every input, including mid-load.
- Write strobes are registered and one cycle wide; address and data are valid in the same cycle.
- Latency from acceptance to write: a byte accepted into an empty FIFO at edge k can strobe at edge k+1 at the earliest, if vram_slot = 1 at edge k+1.
- Push and pop in the same cycle are allowed when the FIFO is full: the pop frees the slot combinationally, so s_ready stays 1 when a pop is certain that cycle.
- With vram_slot tied to 1 and s_valid held high, throughput is one byte per cycle.
- done asserts the cycle after the final write strobe.
- busy deasserts in that same cycle as done.
- The byte counter never wraps; input past N is blocked by the ERR transition.

## Test plan
- **fmt 0, full SCR**: page = 1, 6912 bytes with value n[7:0], vram_slot = 1.
  - Expect 6912 vram_we pulses; the first at 0x4000 and the last at 0x5AFF with data 0xFF.
  - Expect done once and err = 0.
- **fmt 3, Timex with mode byte**: page = 0, vram_slot toggling 1-in-4.
  - Byte 6144 is written at 0x2000; byte 12287 at 0x37FF.
  - Exactly one tmx_we, carrying the value of byte 12288.
  - s_ready drops while the FIFO is full.
- **fmt 1, SCR + palette**: palette bytes 0xC0+i.
  - Expect 64 pal_we pulses, pal_addr 0..63 with data 0xC0..0xFF, then done.
- **Short stream**: fmt 0 with s_last on byte 100.
  - Expect 101 VRAM writes, err = 1, no done, and s_ready = 0 until the next start.
- **Abort mid-load**: abort after 500 bytes with vram_slot = 0.
  - Expect no further write strobes and IDLE the next cycle.
  - A new start succeeds with err = 0.
- **Reset mid-load**: reset_n low for one cycle.
  - All outputs read their reset values the following cycle, and start is accepted afterwards.
